fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/stream_buf2.sv | 87 ++++++++
 rtl/fifo_rd_stream.sv | 74 +++++++
 tb/tb_fifo_rd_stream.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming adapter:
// default data width and the encoding of the output buffer occupancy.
package fifo_pkg;

    localparam int DATA_LEN_DEFAULT = 8;

    // The encoding doubles as the word count, so a state converts
    // straight to the buf_count value without a lookup.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_e;

    // Converts a buffer state into the number of words it represents.
    function automatic logic [1:0] stateToCount(input bufState_e state);
        return 2'(state);
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry registered output buffer with head/tail select. Words are
// written at the tail and presented from the head, in strict FIFO order.
// The head word stays put until it is popped, so the presented data cannot
// change while the consumer is stalling.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wrEn_i,
    input  logic [DATA_LEN-1:0] wrData_i,
    input  logic                popEn_i,
    output logic                valid_o,
    output logic [DATA_LEN-1:0] headData_o,
    output logic [1:0]          count_o
);

    bufState_e           state_q;
    bufState_e           state_d;
    logic                head_q;
    logic                tail_q;
    logic                valid_q;
    logic [DATA_LEN-1:0] mem_q [2];
    logic                popEff;
    logic                wrAccept;

    // A pop only counts when a word is actually presented. A write is refused
    // only when the buffer is full and nothing leaves in the same cycle; the
    // credit logic upstream never lets that happen, so no word is dropped.
    always_comb begin
        popEff   = popEn_i & valid_q;
        wrAccept = wrEn_i & ((state_q != FULL) | popEff);
    end

    // Occupancy moves by at most one step per cycle. A simultaneous write and
    // pop leaves the state unchanged.
    always_comb begin
        state_d = state_q;
        unique case ({wrAccept, popEff})
            2'b10: begin
                unique case (state_q)
                    EMPTY:   state_d = ONE;
                    ONE:     state_d = FULL;
                    default: state_d = FULL;
                endcase
            end
            2'b01: begin
                unique case (state_q)
                    FULL:    state_d = ONE;
                    ONE:     state_d = EMPTY;
                    default: state_d = EMPTY;
                endcase
            end
            default: state_d = state_q;
        endcase
    end

    // State, pointers, storage and the registered valid flag. Reset clears
    // the storage as well, so the presented data reads as zero afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= EMPTY;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            valid_q  <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != EMPTY);
            if (wrAccept) begin
                mem_q[tail_q] <= wrData_i;
                tail_q        <= ~tail_q;
            end
            if (popEff) begin
                head_q <= ~head_q;
            end
        end
    end

    assign valid_o    = valid_q;
    assign headData_o = mem_q[head_q];
    assign count_o    = stateToCount(state_q);

endmodule

// File: rtl/fifo_rd_stream.sv
// Adapter from a FIFO read-strobe interface to a valid/ready stream.
// Read data shows up one cycle after the strobe, so every strobe reserves a
// buffer slot ahead of time; the two-entry buffer absorbs the word still in
// flight when the consumer stalls, which keeps full throughput without loss.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [DATA_LEN-1:0] fifo_rd_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_LEN-1:0] m_data,
    output logic [1:0]          buf_count
);

    logic       inflight_q;
    logic       inflight_d;
    logic       pop;
    logic [2:0] committed;
    logic [2:0] limit;

    // Credit check: a slot is free when the words already held plus the one
    // in flight, less the one leaving this cycle, stay below two. Comparing
    // committed against (2 + pop) is the same test as space >= 1 but cannot
    // wrap around. A full buffer that is being popped with nothing in flight
    // may therefore issue a read in that very cycle.
    always_comb begin
        pop        = m_valid & m_ready;
        committed  = {1'b0, buf_count} + {2'b00, inflight_q};
        limit      = 3'd2 + {2'b00, pop};
        fifo_rd_en = !fifo_empty && !rd_rst && (committed < limit);
        inflight_d = fifo_rd_en;
    end

    // Remembers that a read was issued last cycle, i.e. that fifo_rd_data
    // carries a word which must be captured on this edge.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    stream_buf2 #(
        .DATA_LEN (DATA_LEN)
    ) u_buf (
        .clk_i      (rd_clk),
        .rst_i      (rd_rst),
        .wrEn_i     (inflight_q),
        .wrData_i   (fifo_rd_data),
        .popEn_i    (pop),
        .valid_o    (m_valid),
        .headData_o (m_data),
        .count_o    (buf_count)
    );

    // Invariants of the credit scheme: occupancy never reaches three, a word
    // in flight always has a slot waiting, and a stalled word stays put.
    assert property (@(posedge rd_clk) disable iff (rd_rst)
        buf_count != 2'd3);

    assert property (@(posedge rd_clk) disable iff (rd_rst)
        inflight_q |-> ((buf_count != 2'd2) || pop));

    assert property (@(posedge rd_clk) disable iff (rd_rst)
        (m_valid && !m_ready) |=> $stable(m_data));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO feeds the adapter, a monitor
// records accepted words and read strobes, and each scenario task compares
// the observed words against a queue of expected words in order.
module tb_fifo_rd_stream;

    logic       rd_clk = 1'b0;
    logic       rd_rst;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] buf_count;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] fifoMem [0:4095];
    int         fifoWr    = 0;
    int         fifoRd    = 0;
    logic       fifoFlush = 1'b0;

    logic [7:0] obsData [0:4095];
    int         obsCyc  [0:4095];
    int         rdCyc   [0:4095];
    int         obsWr     = 0;
    int         rdWr      = 0;
    int         cyc       = 0;
    int         emptyViol = 0;
    int         countViol = 0;
    int         rstViol   = 0;
    int         obsRd     = 0;

    logic [7:0] expQ [$];

    fifo_rd_stream #(
        .DATA_LEN (8)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .buf_count    (buf_count)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (fifoRd == fifoWr);

    // Behavioural FIFO: a strobe pops one word which appears on the read
    // data one cycle later; otherwise the read data carries junk.
    always @(posedge rd_clk) begin
        if (fifoFlush) begin
            fifoRd <= fifoWr;
        end else if (fifo_rd_en === 1'b1 && fifoRd != fifoWr) begin
            fifo_rd_data <= fifoMem[fifoRd % 4096];
            fifoRd       <= fifoRd + 1;
        end else begin
            fifo_rd_data <= 8'($urandom);
        end
    end

    // Monitor on the falling edge: records accepted words, read strobes and
    // any protocol violation seen along the way.
    always @(negedge rd_clk) begin
        cyc <= cyc + 1;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            obsData[obsWr % 4096] <= m_data;
            obsCyc[obsWr % 4096]  <= cyc;
            obsWr                 <= obsWr + 1;
        end
        if (fifo_rd_en === 1'b1) begin
            rdCyc[rdWr % 4096] <= cyc;
            rdWr               <= rdWr + 1;
        end
        if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) emptyViol <= emptyViol + 1;
        if (buf_count === 2'd3) countViol <= countViol + 1;
        if (rd_rst === 1'b1 && fifo_rd_en !== 1'b0) rstViol <= rstViol + 1;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic pushWord(input logic [7:0] w, input bit expectIt);
        fifoMem[fifoWr % 4096] = w;
        fifoWr = fifoWr + 1;
        if (expectIt) expQ.push_back(w);
    endtask

    task automatic applyStimulus(input int nWords, input logic [7:0] first);
        for (int i = 0; i < nWords; i++) pushWord(8'(first + 8'(i)), 1'b1);
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rd_rst  = 1'b1;
        m_ready = 1'b1;
        pushWord(8'h3C, 1'b0);
        pushWord(8'h3D, 1'b0);
        for (int i = 0; i < 2; i++) begin
            waitCycle();
            @(negedge rd_clk);
            nCompared++;
            if (fifo_rd_en !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_rd_en: got %b, required 0", fifo_rd_en);
            end
            nCompared++;
            if (m_valid !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_m_valid: got %b, required 0", m_valid);
            end
            nCompared++;
            if (buf_count !== 2'd0) begin
                nMismatched++;
                $display("[TB] FAIL reset_buf_count: got %0d, required 0", buf_count);
            end
        end
        got = m_data;
        nCompared++;
        if (got !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_m_data: got %h, required 00", got);
        end
        waitCycle();
        fifoFlush = 1'b1;
        waitCycle();
        fifoFlush = 1'b0;
        rd_rst    = 1'b0;
        expQ.delete();
        obsRd = obsWr;
    endtask

    task automatic test_single();
        int rd0;
        int ob0;
        logic [7:0] got;
        logic [7:0] expWord;
        m_ready = 1'b1;
        rd0 = rdWr;
        ob0 = obsWr;
        pushWord(8'hA5, 1'b1);
        repeat (8) waitCycle();
        nCompared++;
        if (rdWr - rd0 != 1) begin
            nMismatched++;
            $display("[TB] FAIL single_reads: got %0d, required 1", rdWr - rd0);
        end
        nCompared++;
        if (obsWr - ob0 != 1) begin
            nMismatched++;
            $display("[TB] FAIL single_transfers: got %0d, required 1", obsWr - ob0);
        end
        nCompared++;
        if (obsCyc[ob0 % 4096] != rdCyc[rd0 % 4096] + 2) begin
            nMismatched++;
            $display("[TB] FAIL single_latency: got %0d, required %0d",
                     obsCyc[ob0 % 4096] - rdCyc[rd0 % 4096], 2);
        end
        @(negedge rd_clk);
        nCompared++;
        if (m_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_valid_after: got %b, required 0", m_valid);
        end
        while (obsRd != obsWr) begin
            got = obsData[obsRd % 4096];
            obsRd++;
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL single_extra: got %h, required no word", got);
            end else begin
                expWord = expQ.pop_front();
                if (got !== expWord) begin
                    nMismatched++;
                    $display("[TB] FAIL single_data: got %h, required %h", got, expWord);
                end
            end
        end
        waitCycle();
    endtask

    task automatic test_streaming();
        int rd0;
        int ob0;
        int gaps;
        logic [7:0] got;
        logic [7:0] expWord;
        m_ready = 1'b1;
        rd0 = rdWr;
        ob0 = obsWr;
        applyStimulus(16, 8'h01);
        repeat (24) waitCycle();
        nCompared++;
        if (obsWr - ob0 != 16) begin
            nMismatched++;
            $display("[TB] FAIL stream_count: got %0d, required 16", obsWr - ob0);
        end
        nCompared++;
        if (obsCyc[ob0 % 4096] != rdCyc[rd0 % 4096] + 2) begin
            nMismatched++;
            $display("[TB] FAIL stream_latency: got %0d, required 2",
                     obsCyc[ob0 % 4096] - rdCyc[rd0 % 4096]);
        end
        gaps = 0;
        for (int i = ob0 + 1; i < obsWr; i++) begin
            if (obsCyc[i % 4096] != obsCyc[(i - 1) % 4096] + 1) gaps++;
        end
        nCompared++;
        if (gaps != 0) begin
            nMismatched++;
            $display("[TB] FAIL stream_gaps: got %0d, required 0", gaps);
        end
        while (obsRd != obsWr) begin
            got = obsData[obsRd % 4096];
            obsRd++;
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL stream_extra: got %h, required no word", got);
            end else begin
                expWord = expQ.pop_front();
                if (got !== expWord) begin
                    nMismatched++;
                    $display("[TB] FAIL stream_data: got %h, required %h", got, expWord);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int rd0;
        int stableBad;
        logic [7:0] got;
        logic [7:0] expWord;
        m_ready   = 1'b0;
        rd0       = rdWr;
        stableBad = 0;
        applyStimulus(5, 8'h01);
        for (int i = 0; i < 10; i++) begin
            waitCycle();
            @(negedge rd_clk);
            if (m_valid === 1'b1 && m_data !== 8'h01) stableBad++;
        end
        nCompared++;
        if (buf_count !== 2'd2) begin
            nMismatched++;
            $display("[TB] FAIL bp_buf_count: got %0d, required 2", buf_count);
        end
        nCompared++;
        if (rdWr - rd0 != 2) begin
            nMismatched++;
            $display("[TB] FAIL bp_reads: got %0d, required 2", rdWr - rd0);
        end
        nCompared++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
            nMismatched++;
            $display("[TB] FAIL bp_head: got valid=%b data=%h, required valid=1 data=01",
                     m_valid, m_data);
        end
        nCompared++;
        if (stableBad != 0) begin
            nMismatched++;
            $display("[TB] FAIL bp_stable: got %0d changes, required 0", stableBad);
        end
        waitCycle();
        m_ready = 1'b1;
        @(negedge rd_clk);
        nCompared++;
        if (fifo_rd_en !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL bp_full_pop_read: got %b, required 1", fifo_rd_en);
        end
        repeat (12) waitCycle();
        while (obsRd != obsWr) begin
            got = obsData[obsRd % 4096];
            obsRd++;
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL bp_extra: got %h, required no word", got);
            end else begin
                expWord = expQ.pop_front();
                if (got !== expWord) begin
                    nMismatched++;
                    $display("[TB] FAIL bp_data: got %h, required %h", got, expWord);
                end
            end
        end
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL bp_missing: got %0d undelivered, required 0", expQ.size());
        end
    endtask

    task automatic test_random();
        int pushed;
        int budget;
        int n;
        logic [7:0] got;
        logic [7:0] expWord;
        pushed = 0;
        budget = 3000;
        while (budget > 0 && !(pushed == 200 && expQ.size() == 0)) begin
            waitCycle();
            budget--;
            m_ready = 1'($urandom % 2);
            if (pushed < 200 && ($urandom % 2) == 1) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n && pushed < 200; k++) begin
                    pushWord(8'($urandom), 1'b1);
                    pushed++;
                end
            end
            while (obsRd != obsWr) begin
                got = obsData[obsRd % 4096];
                obsRd++;
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_extra: got %h, required no word", got);
                end else begin
                    expWord = expQ.pop_front();
                    if (got !== expWord) begin
                        nMismatched++;
                        $display("[TB] FAIL rand_data: got %h, required %h", got, expWord);
                    end
                end
            end
        end
        m_ready = 1'b1;
        nCompared++;
        if (pushed != 200 || expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL rand_complete: got %0d pushed %0d pending, required 200 pushed 0 pending",
                     pushed, expQ.size());
        end
        nCompared++;
        if (emptyViol != 0) begin
            nMismatched++;
            $display("[TB] FAIL rand_read_empty: got %0d, required 0", emptyViol);
        end
        nCompared++;
        if (countViol != 0) begin
            nMismatched++;
            $display("[TB] FAIL rand_count_range: got %0d, required 0", countViol);
        end
        nCompared++;
        if (rstViol != 0) begin
            nMismatched++;
            $display("[TB] FAIL rd_en_in_reset: got %0d, required 0", rstViol);
        end
    endtask

    task automatic test_reset_mid();
        int delays [2];
        logic [7:0] got;
        logic [7:0] expWord;
        logic [1:0] expCount;
        delays[0] = 2;
        delays[1] = 4;
        foreach (delays[j]) begin
            waitCycle();
            m_ready = 1'b0;
            pushWord(8'hC0, 1'b0);
            pushWord(8'hC1, 1'b0);
            pushWord(8'hC2, 1'b0);
            pushWord(8'hC3, 1'b0);
            repeat (delays[j]) waitCycle();
            expCount = (delays[j] == 4) ? 2'd2 : 2'd1;
            nCompared++;
            if (buf_count !== expCount) begin
                nMismatched++;
                $display("[TB] FAIL rstmid_pre_count: got %0d, required %0d", buf_count, expCount);
            end
            rd_rst    = 1'b1;
            fifoFlush = 1'b1;
            waitCycle();
            fifoFlush = 1'b0;
            @(negedge rd_clk);
            nCompared++;
            if (m_valid !== 1'b0 || buf_count !== 2'd0 || m_data !== 8'h00) begin
                nMismatched++;
                $display("[TB] FAIL rstmid_cleared: got valid=%b count=%0d data=%h, required 0/0/00",
                         m_valid, buf_count, m_data);
            end
            waitCycle();
            rd_rst = 1'b0;
            expQ.delete();
            obsRd   = obsWr;
            m_ready = 1'b1;
            pushWord(8'(8'h70 + 8'(delays[j])), 1'b1);
            repeat (8) waitCycle();
            while (obsRd != obsWr) begin
                got = obsData[obsRd % 4096];
                obsRd++;
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL rstmid_stale: got %h, required no word", got);
                end else begin
                    expWord = expQ.pop_front();
                    if (got !== expWord) begin
                        nMismatched++;
                        $display("[TB] FAIL rstmid_data: got %h, required %h", got, expWord);
                    end
                end
            end
            nCompared++;
            if (expQ.size() != 0) begin
                nMismatched++;
                $display("[TB] FAIL rstmid_missing: got %0d undelivered, required 0", expQ.size());
            end
        end
    endtask

    initial begin
        rd_rst  = 1'b1;
        m_ready = 1'b0;
        test_reset();
        $display("[TB] reset scenario done");
        test_single();
        $display("[TB] single word scenario done");
        test_streaming();
        $display("[TB] streaming scenario done");
        test_backpressure();
        $display("[TB] backpressure scenario done");
        test_random();
        $display("[TB] random scenario done");
        test_reset_mid();
        $display("[TB] mid-operation reset scenario done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
